// File: rtl/tdc_pkg.sv
// tdc_pkg: shared defaults, width helpers and the period-averager state type
// for the TDC thermometer decoder.
package tdc_pkg;

  localparam int N_STAGES_DEF = 64;
  localparam int AVG_LOG2_DEF = 3;

  // Position outputs must hold 0..N_STAGES, the top value being the sentinel.
  function automatic int pos_w(input int n_stages);
    return $clog2(n_stages + 1);
  endfunction

  // Absent-edge marker: one past the last valid stage index.
  function automatic int sentinel(input int n_stages);
    return n_stages;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } avg_state_e;

endpackage

// File: rtl/tdc_decoder_if.sv
// tdc_decoder_if: sample input and decoded result bundle of the TDC decoder.
//   sample_en/therm          : qualified thermometer word from the sampling flops
//   valid/rise_pos/fall_pos  : per-sample edge positions (sentinel when absent)
//   no_rise/no_fall/bubble   : per-sample flags
//   period_avg/period_valid  : running DCO period average in delay stages
// master = sample source, slave = decoder.
interface tdc_decoder_if #(parameter int N_STAGES = tdc_pkg::N_STAGES_DEF);
  localparam int POS_W = tdc_pkg::pos_w(N_STAGES);

  logic                sample_en;
  logic [N_STAGES-1:0] therm;
  logic                valid;
  logic [POS_W-1:0]    rise_pos;
  logic [POS_W-1:0]    fall_pos;
  logic                no_rise;
  logic                no_fall;
  logic                bubble;
  logic [POS_W:0]      period_avg;
  logic                period_valid;

  modport master (
    output sample_en, therm,
    input  valid, rise_pos, fall_pos, no_rise, no_fall, bubble,
           period_avg, period_valid
  );

  modport slave (
    input  sample_en, therm,
    output valid, rise_pos, fall_pos, no_rise, no_fall, bubble,
           period_avg, period_valid
  );
endinterface

// File: rtl/tdc_edge_find.sv
// tdc_edge_find: priority scan for the lowest edge in a bubble-corrected
// thermometer vector.
//   b     : corrected vector, bit 0 nearest the delay-line input
//   pos   : index i of the first b[i-1]->b[i] edge of the selected polarity,
//           N when no such edge exists
//   found : edge present
// RISE=1 scans for 0->1, RISE=0 for 1->0.
module tdc_edge_find #(
  parameter int   N     = 64,
  parameter int   POS_W = 7,
  parameter logic RISE  = 1'b1
) (
  input  logic [N-1:0]     b,
  output logic [POS_W-1:0] pos,
  output logic             found
);

  logic [N-1:1] hit;

  for (genvar i = 1; i < N; i++) begin : g_hit
    assign hit[i] = RISE ? (~b[i-1] &  b[i]) : (b[i-1] & ~b[i]);
  end

  // Scanning downward leaves the lowest hit as the final assignment.
  always_comb begin
    pos   = POS_W'(N);
    found = 1'b0;
    for (int i = N-1; i >= 1; i--) begin
      if (hit[i]) begin
        pos   = POS_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdc_decoder.sv
// tdc_decoder: three-stage decoder for the TDC delay-line thermometer word.
//   stage 1 : capture therm on sample_en
//   stage 2 : 3-tap majority bubble correction, rise/fall priority scan
//   stage 3 : register results, form period sample p = 2*|fall-rise|
//   averager: accumulates 2**AVG_LOG2 usable samples, publishes the mean
// Ports: clk, rst (sync, active high), bus (tdc_decoder_if.slave).
module tdc_decoder
  import tdc_pkg::*;
#(
  parameter int N_STAGES = N_STAGES_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic          clk,
  input  logic          rst,
  tdc_decoder_if.slave  bus
);

  localparam int POS_W  = pos_w(N_STAGES);
  localparam int P_W    = POS_W + 1;
  localparam int ACC_W  = P_W + AVG_LOG2;
  localparam int STAGES = 3;
  localparam logic [POS_W-1:0] SENT = POS_W'(sentinel(N_STAGES));

  logic [STAGES:1] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:1], bus.sample_en};
  end

  // ---- stage 1: capture
  logic [N_STAGES-1:0] t;

  always_ff @(posedge clk) begin
    if (bus.sample_en) t <= bus.therm;
  end

  // ---- stage 2: bubble correction and edge search
  logic [N_STAGES-1:0] b;
  logic [POS_W-1:0]    rise_c, fall_c;
  logic                rise_ok, fall_ok;

  // End stages have only one neighbour, so they pass through uncorrected.
  assign b[0]          = t[0];
  assign b[N_STAGES-1] = t[N_STAGES-1];
  for (genvar i = 1; i < N_STAGES-1; i++) begin : g_maj
    assign b[i] = (t[i-1] & t[i]) | (t[i] & t[i+1]) | (t[i-1] & t[i+1]);
  end

  tdc_edge_find #(.N(N_STAGES), .POS_W(POS_W), .RISE(1'b1)) u_rise (
    .b(b), .pos(rise_c), .found(rise_ok)
  );

  tdc_edge_find #(.N(N_STAGES), .POS_W(POS_W), .RISE(1'b0)) u_fall (
    .b(b), .pos(fall_c), .found(fall_ok)
  );

  logic [POS_W-1:0] s2_rise, s2_fall;
  logic             s2_rise_ok, s2_fall_ok, s2_bub;

  always_ff @(posedge clk) begin
    if (vld_pipe[1]) begin
      s2_rise    <= rise_c;
      s2_fall    <= fall_c;
      s2_rise_ok <= rise_ok;
      s2_fall_ok <= fall_ok;
      s2_bub     <= (b != t);
    end
  end

  // ---- stage 3: results and period sample
  logic [POS_W-1:0] diff;
  logic [POS_W-1:0] s3_rise, s3_fall;
  logic             s3_no_rise, s3_no_fall, s3_bub, s3_use;
  logic [P_W-1:0]   s3_p;

  assign diff = (s2_fall > s2_rise) ? (s2_fall - s2_rise) : (s2_rise - s2_fall);

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_rise    <= SENT;
      s3_fall    <= SENT;
      s3_no_rise <= 1'b1;
      s3_no_fall <= 1'b1;
      s3_bub     <= 1'b0;
      s3_use     <= 1'b0;
      s3_p       <= '0;
    end else if (vld_pipe[2]) begin
      s3_rise    <= s2_rise;
      s3_fall    <= s2_fall;
      s3_no_rise <= ~s2_rise_ok;
      s3_no_fall <= ~s2_fall_ok;
      s3_bub     <= s2_bub;
      s3_use     <= s2_rise_ok & s2_fall_ok;
      s3_p       <= {diff, 1'b0};
    end
  end

  assign bus.valid    = vld_pipe[3];
  assign bus.rise_pos = s3_rise;
  assign bus.fall_pos = s3_fall;
  assign bus.no_rise  = s3_no_rise;
  assign bus.no_fall  = s3_no_fall;
  assign bus.bubble   = s3_bub;

  // ---- period averager
  avg_state_e          state, state_n;
  logic [ACC_W-1:0]    acc, acc_n, sum;
  logic [AVG_LOG2-1:0] cnt, cnt_n;
  logic [P_W-1:0]      avg, avg_n;
  logic                pv, pv_n;
  logic                take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      avg   <= '0;
      pv    <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      avg   <= avg_n;
      pv    <= pv_n;
    end
  end

  assign take = vld_pipe[3] & s3_use;
  assign sum  = acc + ACC_W'(s3_p);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    avg_n   = avg;
    pv_n    = pv;
    unique case (state)
      IDLE:    if (vld_pipe[3]) state_n = ACQ;
      ACQ,
      TRACK:   ;
      default: state_n = IDLE;
    endcase
    // The very first usable sample is counted even while leaving IDLE.
    if (take) begin
      if (cnt == '1) begin
        avg_n   = sum[AVG_LOG2 +: P_W];
        acc_n   = '0;
        cnt_n   = '0;
        pv_n    = 1'b1;
        state_n = TRACK;
      end else begin
        acc_n = sum;
        cnt_n = cnt + 1'b1;
      end
    end
  end

  assign bus.period_avg   = avg;
  assign bus.period_valid = pv;

endmodule
